sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_sequencer.sv | 123 ++++++++++++
 tb/tb_sound_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: a small command FIFO of {control, duration} pairs
// is played back into one control register that drives the sound generator.
module sound_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TICKS_PER_UNIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stb_16us,
  input  logic                    io_wr,
  input  logic [7:0]              io_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_ctl,
  input  logic [7:0]              cmd_dur,
  output logic [2:0]              mixer_ctl,
  output logic                    vco_sel,
  output logic                    vco_pitch,
  output logic [1:0]              envsel,
  output logic                    inhibit,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    seq_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUB_W = $clog2(TICKS_PER_UNIT);
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_UNIT - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_nxt;
  logic [7:0]         ctl, ctl_nxt;
  logic [7:0]         dur_ctr, dur_nxt;
  logic [SUB_W-1:0]   sub, sub_nxt;
  logic               done_nxt;
  logic [7:0]         mem_ctl [DEPTH];
  logic [7:0]         mem_dur [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               can_push, push, pop;

  // Reset is kept out of the push path so it only gates the visible handshake.
  assign can_push  = (level != FULL) & ~io_wr;
  assign cmd_ready = can_push & ~rst;
  assign push      = cmd_valid & can_push;

  assign envsel    = ctl[7:6];
  assign mixer_ctl = ctl[5:3];
  assign vco_sel   = ctl[2];
  assign vco_pitch = ctl[1];
  assign inhibit   = ~ctl[0];
  assign busy      = (state == PLAY);

  always_comb begin
    state_nxt = state;
    ctl_nxt   = ctl;
    dur_nxt   = dur_ctr;
    sub_nxt   = sub;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    if (io_wr) begin
      ctl_nxt   = io_data;
      dur_nxt   = '0;
      sub_nxt   = '0;
      state_nxt = IDLE;
    end else if (state == PLAY && dur_ctr != 8'd0) begin
      if (stb_16us) begin
        sub_nxt = sub + 1'b1;
        if (sub == SUB_LAST) dur_nxt = dur_ctr - 8'd1;
      end
    end else if (level != '0) begin
      // Covers both the idle start and the gapless hand-over on expiry.
      pop       = 1'b1;
      ctl_nxt   = mem_ctl[rd_ptr];
      dur_nxt   = mem_dur[rd_ptr];
      sub_nxt   = '0;
      state_nxt = PLAY;
    end else if (state == PLAY) begin
      ctl_nxt   = {ctl[7:1], 1'b0};
      done_nxt  = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctl      <= 8'h00;
      dur_ctr  <= 8'd0;
      sub      <= '0;
      seq_done <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      state    <= state_nxt;
      ctl      <= ctl_nxt;
      dur_ctr  <= dur_nxt;
      sub      <= sub_nxt;
      seq_done <= done_nxt;
      if (io_wr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, push};
        rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, pop};
        level  <= level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
    end
  end

  // FIFO storage is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctl[wr_ptr] <= cmd_ctl;
      mem_dur[wr_ptr] <= cmd_dur;
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sound_sequencer;

  localparam int DEPTH = 4;
  localparam int TPU   = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb_16us = 1'b0;
  logic       io_wr = 1'b0;
  logic [7:0] io_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_ctl = 8'h00;
  logic [7:0] cmd_dur = 8'h00;
  logic [2:0] mixer_ctl;
  logic       vco_sel, vco_pitch, inhibit, busy, seq_done;
  logic [1:0] envsel;
  logic [2:0] level;

  sound_sequencer #(.DEPTH(DEPTH), .TICKS_PER_UNIT(TPU)) dut (
    .clk(clk), .rst(rst), .stb_16us(stb_16us), .io_wr(io_wr), .io_data(io_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctl(cmd_ctl), .cmd_dur(cmd_dur),
    .mixer_ctl(mixer_ctl), .vco_sel(vco_sel), .vco_pitch(vco_pitch), .envsel(envsel),
    .inhibit(inhibit), .busy(busy), .level(level), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] shown_ctl();
    return {envsel, mixer_ctl, vco_sel, vco_pitch, ~inhibit};
  endfunction

  // Reference model: a queue of pending sounds and a remaining-strobe count.
  typedef struct { logic [7:0] c; logic [7:0] d; } ent_t;
  ent_t       mq[$];
  logic [7:0] m_ctl  = 8'h00;
  bit         m_play = 1'b0;
  int         m_rem  = 0;
  bit         m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ctl = 8'h00; m_play = 1'b0; m_rem = 0; m_done = 1'b0;
    end else begin
      bit   acc;
      int   n;
      ent_t e;
      n      = mq.size();
      acc    = cmd_valid && (n != DEPTH) && !io_wr;
      m_done = 1'b0;
      if (io_wr) begin
        m_ctl = io_data;
        mq.delete();
        m_play = 1'b0;
      end else begin
        if (m_play && m_rem > 0) begin
          if (stb_16us) m_rem--;
        end else if (n > 0) begin
          e = mq.pop_front();
          m_ctl = e.c; m_rem = e.d * TPU; m_play = 1'b1;
        end else if (m_play) begin
          m_ctl[0] = 1'b0; m_done = 1'b1; m_play = 1'b0;
        end
        if (acc) mq.push_back('{cmd_ctl, cmd_dur});
      end
    end
  end

  typedef struct { logic [7:0] c; logic s; logic d; } tr_t;
  tr_t trace[$];

  always @(negedge clk) begin
    chk("ctl",       {24'd0, shown_ctl()}, {24'd0, m_ctl});
    chk("busy",      {31'd0, busy},        {31'd0, m_play});
    chk("level",     {29'd0, level},       mq.size());
    chk("seq_done",  {31'd0, seq_done},    {31'd0, m_done});
    chk("cmd_ready", {31'd0, cmd_ready},   {31'd0, (!rst && mq.size() != DEPTH && !io_wr)});
    trace.push_back('{shown_ctl(), stb_16us, seq_done});
  end

  // Strobe every fourth clock keeps runs short while preserving the counting rules.
  initial begin
    forever begin
      @(posedge clk); #1 stb_16us = 1'b1;
      @(posedge clk); #1 stb_16us = 1'b0;
      @(posedge clk); @(posedge clk);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; io_wr = 1'b0; cmd_valid = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] d, output int waited);
    bit ok;
    cmd_valid = 1'b1; cmd_ctl = c; cmd_dur = d; waited = 0;
    while (1) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
      if (ok) break;
      waited++;
      if (waited >= 2000) begin chk("push_timeout", 0, 1); break; end
    end
    cmd_valid = 1'b0;
  endtask

  function automatic int cnt_ctl(input logic [7:0] v);
    int n = 0;
    foreach (trace[i]) if (trace[i].c == v) n++;
    return n;
  endfunction

  function automatic int cnt_stb_ctl(input logic [7:0] v);
    int n = 0;
    foreach (trace[i]) if (trace[i].c == v && trace[i].s) n++;
    return n;
  endfunction

  function automatic int cnt_done();
    int n = 0;
    foreach (trace[i]) if (trace[i].d) n++;
    return n;
  endfunction

  function automatic int cnt_sounding();
    int n = 0;
    foreach (trace[i]) if (trace[i].c[0]) n++;
    return n;
  endfunction

  function automatic int cnt_stb();
    int n = 0;
    foreach (trace[i]) if (trace[i].s) n++;
    return n;
  endfunction

  function automatic int tail_after_stb(input logic [7:0] v);
    int n = 0;
    foreach (trace[i]) if (trace[i].c == v) n = trace[i].s ? 0 : n + 1;
    return n;
  endfunction

  initial begin
    int w;
    logic [7:0] runs[$];

    // Reset state
    @(negedge clk);
    chk("rst_inhibit", {31'd0, inhibit}, 1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    do_reset();
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // CPU direct write of C5, then persistence
    io_wr = 1'b1; io_data = 8'hC5;
    step(1);
    io_wr = 1'b0;
    @(negedge clk);
    chk("c5_mixer", {29'd0, mixer_ctl}, 0);
    chk("c5_vco_sel", {31'd0, vco_sel}, 1);
    chk("c5_vco_pitch", {31'd0, vco_pitch}, 0);
    chk("c5_envsel", {30'd0, envsel}, 3);
    chk("c5_inhibit", {31'd0, inhibit}, 0);
    chk("c5_busy", {31'd0, busy}, 0);
    step(50);
    chk("c5_persist", {24'd0, shown_ctl()}, 8'hC5);

    // Single entry 09 for two units
    do_reset();
    trace.delete();
    push(8'h09, 8'd2, w);
    step(600);
    chk("e09_strobes", cnt_stb_ctl(8'h09), 128);
    chk("e09_tail", tail_after_stb(8'h09), 1);
    chk("e09_done", cnt_done(), 1);
    chk("e09_inhibit", {31'd0, inhibit}, 1);
    chk("e09_mixer", {29'd0, mixer_ctl}, 1);
    chk("e09_busy", {31'd0, busy}, 0);

    // Three entries back to back, middle one zero-length
    do_reset();
    trace.delete();
    push(8'h01, 8'd1, w);
    push(8'h0B, 8'd0, w);
    push(8'h11, 8'd1, w);
    step(650);
    runs.delete();
    foreach (trace[i]) if (runs.size() == 0 || runs[$] != trace[i].c) runs.push_back(trace[i].c);
    chk("seq_runs", runs.size(), 5);
    if (runs.size() == 5) begin
      chk("seq_r0", {24'd0, runs[0]}, 8'h00);
      chk("seq_r1", {24'd0, runs[1]}, 8'h01);
      chk("seq_r2", {24'd0, runs[2]}, 8'h0B);
      chk("seq_r3", {24'd0, runs[3]}, 8'h11);
      chk("seq_r4", {24'd0, runs[4]}, 8'h10);
    end
    chk("seq_0b_len", cnt_ctl(8'h0B), 1);
    chk("seq_done_cnt", cnt_done(), 1);

    // Fill to DEPTH, fifth pending push held off until the first pop
    do_reset();
    push(8'h01, 8'd1, w);
    push(8'h03, 8'd1, w);
    push(8'h05, 8'd1, w);
    push(8'h07, 8'd1, w);
    push(8'h09, 8'd1, w);
    cmd_valid = 1'b1; cmd_ctl = 8'h0D; cmd_dur = 8'd1;
    @(negedge clk);
    chk("full_level", {29'd0, level}, 4);
    chk("full_ready", {31'd0, cmd_ready}, 0);
    push(8'h0D, 8'd1, w);
    chk("full_waited", (w > 200 && w < 300), 1);
    @(negedge clk);
    chk("full_level_after", {29'd0, level}, 4);
    io_wr = 1'b1; io_data = 8'h00;
    step(1);
    io_wr = 1'b0;

    // CPU write during PLAY with two queued, simultaneous push refused
    do_reset();
    push(8'h01, 8'd1, w);
    push(8'h03, 8'd1, w);
    push(8'h05, 8'd1, w);
    @(negedge clk);
    chk("cpu_pre_level", {29'd0, level}, 2);
    chk("cpu_pre_busy", {31'd0, busy}, 1);
    step(0);
    io_wr = 1'b1; io_data = 8'h00;
    cmd_valid = 1'b1; cmd_ctl = 8'h77; cmd_dur = 8'd5;
    @(negedge clk);
    chk("cpu_ready", {31'd0, cmd_ready}, 0);
    step(1);
    io_wr = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("cpu_inhibit", {31'd0, inhibit}, 1);
    chk("cpu_level", {29'd0, level}, 0);
    chk("cpu_busy", {31'd0, busy}, 0);
    chk("cpu_seq_done", {31'd0, seq_done}, 0);
    trace.delete();
    step(300);
    chk("cpu_quiet_done", cnt_done(), 0);
    chk("cpu_quiet_sound", cnt_sounding(), 0);

    // Reset mid-PLAY discards queued entries
    do_reset();
    push(8'h01, 8'd1, w);
    push(8'h03, 8'd1, w);
    push(8'h05, 8'd1, w);
    push(8'h07, 8'd1, w);
    step(20);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    trace.delete();
    step(4010);
    chk("rstmid_strobes", (cnt_stb() >= 1000), 1);
    chk("rstmid_sound", cnt_sounding(), 0);
    chk("rstmid_done", cnt_done(), 0);
    chk("rstmid_level", {29'd0, level}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
